mc8051_mem_arbiter: RTL and testbench

//  Shares one single-port code/XRAM memory between three requesters: core instruction fetch
//  (IF, id 0), core MOVX data access (DX, id 1) and debug port (DBG, id 2). Registers the

---
 rtl/mc8051_mem_arbiter_if.sv | 30 +++
 rtl/mc8051_mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mc8051_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc8051_mem_arbiter_if.sv
// Bus bundle between the mc8051 requesters, the memory arbiter and the code/XRAM macro.
// Requester fields are packed per id: id i occupies [i*AW +: AW] / [i*DW +: DW].
interface mc8051_mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic [2:0]      req;
    logic [2:0]      we;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      ack;
    logic [DW-1:0]   rdata;
    logic [1:0]      gnt_id;
    logic            busy;
    logic            mem_cs;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output ack, rdata, gnt_id, busy, mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  ack, rdata, gnt_id, busy, mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mc8051_mem_arbiter.sv
// Shares one single-port code/XRAM macro between IF (0), DX (1) and DBG (2) requesters.
// Define MC8051_ARB_RR_EN for round-robin arbitration; default is fixed priority DBG > DX > IF.
//
// state  | meaning
// IDLE   | sample req, latch winner's command and id
// ACCESS | single mem_cs cycle with the latched command
// WAIT   | read latency countdown, mem_rdata captured on the last cycle
// RESP   | one-cycle ack to the owner, req ignored
module mc8051_mem_arbiter #(
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    mc8051_mem_arbiter_if.slave bus
);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("mc8051_mem_arbiter: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic          cmd_we_q, cmd_we_d;
    logic [2:0]    ack_q, ack_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    gnt_id_q, gnt_id_d;
    logic          busy_q, busy_d;
    logic          mem_cs_q, mem_cs_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic [1:0]    win_id;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

`ifdef MC8051_ARB_RR_EN
    logic [1:0] last_gnt_q, last_gnt_d;
    logic [1:0] pri0, pri1, pri2;

    // Search starts at the id after the last grant and walks the ring 0->1->2->0.
    always_comb begin
        pri0 = 2'd0;
        pri1 = 2'd1;
        pri2 = 2'd2;
        case (last_gnt_q)
            2'd0:    begin pri0 = 2'd1; pri1 = 2'd2; pri2 = 2'd0; end
            2'd1:    begin pri0 = 2'd2; pri1 = 2'd0; pri2 = 2'd1; end
            default: ;
        endcase
        win_id = pri2;
        if (bus.req[pri1]) win_id = pri1;
        if (bus.req[pri0]) win_id = pri0;
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (state_q == S_IDLE && |bus.req) last_gnt_d = win_id;
    end

    always_ff @(posedge clk) begin
        if (reset) last_gnt_q <= 2'd2;
        else       last_gnt_q <= last_gnt_d;
    end
`else
    always_comb begin
        win_id = 2'd0;
        if (bus.req[1]) win_id = 2'd1;
        if (bus.req[2]) win_id = 2'd2;
    end
`endif

    always_comb begin
        win_we    = bus.we[win_id];
        win_addr  = bus.addr[int'(win_id) * AW +: AW];
        win_wdata = bus.wdata[int'(win_id) * DW +: DW];
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        cmd_we_d    = cmd_we_q;
        ack_d       = 3'b000;
        rdata_d     = rdata_q;
        gnt_id_d    = gnt_id_q;
        mem_cs_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_d     = S_ACCESS;
                    gnt_id_d    = win_id;
                    cmd_we_d    = win_we;
                    mem_cs_d    = 1'b1;
                    mem_we_d    = win_we;
                    mem_addr_d  = win_addr;
                    mem_wdata_d = win_wdata;
                end
            end
            S_ACCESS: begin
                if (cmd_we_q) begin
                    state_d = S_RESP;
                    ack_d   = 3'b001 << gnt_id_q;
                end else begin
                    state_d    = S_WAIT;
                    wait_cnt_d = WAIT_LOAD;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    ack_d   = 3'b001 << gnt_id_q;
                    rdata_d = bus.mem_rdata;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 4'd0;
            cmd_we_q    <= 1'b0;
            ack_q       <= 3'b000;
            rdata_q     <= '0;
            gnt_id_q    <= 2'd0;
            busy_q      <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            cmd_we_q    <= cmd_we_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            gnt_id_q    <= gnt_id_d;
            busy_q      <= busy_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.busy      = busy_q;
    assign bus.mem_cs    = mem_cs_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mc8051_mem_arbiter.sv
// Bench for mc8051_mem_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (start cycle, owner, command, expected ack cycle).
module tb_mc8051_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int WC = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc8051_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mc8051_mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(WC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // transaction-level model
    bit            txn_active;
    bit            idle_now;
    int            t_start, t_ack;
    logic [1:0]    t_id;
    bit            t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    logic [1:0]    e_gnt;
    int            last_gnt;
    logic [DW-1:0] hist [64];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] pick(input logic [2:0] r);
`ifdef MC8051_ARB_RR_EN
        for (int k = 1; k <= 3; k++)
            if (r[(last_gnt + k) % 3]) return 2'((last_gnt + k) % 3);
        return 2'd0;
`else
        if (r[2]) return 2'd2;
        if (r[1]) return 2'd1;
        return 2'd0;
`endif
    endfunction

    // Advance to the middle of the next cycle and compare every output with the model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        idle_now = !txn_active;
        if (txn_active && cyc == t_start + 1) begin
            e_addr  = t_addr;
            e_wdata = t_wdata;
            e_gnt   = t_id;
        end
        if (txn_active && cyc == t_ack && !t_we)
            e_rdata = hist[(t_start + 1 + WC) % 64];
        check("busy",      bus.busy,   txn_active && cyc > t_start);
        check("mem_cs",    bus.mem_cs, txn_active && cyc == t_start + 1);
        check("mem_we",    bus.mem_we, txn_active && cyc == t_start + 1 && t_we);
        check("ack",       bus.ack,    (txn_active && cyc == t_ack) ? (3'b001 << t_id) : 3'b000);
        check("mem_addr",  bus.mem_addr,  e_addr);
        check("mem_wdata", bus.mem_wdata, e_wdata);
        check("rdata",     bus.rdata,     e_rdata);
        check("gnt_id",    bus.gnt_id,    e_gnt);
        if (txn_active && cyc == t_ack) txn_active = 0;
    endtask

    // Latch this cycle's stimulus into the model (what the DUT samples at the next edge).
    task automatic commit();
        bus.mem_rdata = DW'($urandom);
        hist[cyc % 64] = bus.mem_rdata;
        if (reset) begin
            txn_active = 0;
            e_addr = '0; e_wdata = '0; e_rdata = '0; e_gnt = '0;
            last_gnt = 2;
        end else if (idle_now && bus.req != 3'b000) begin
            t_id       = pick(bus.req);
            t_start    = cyc;
            t_we       = bus.we[t_id];
            t_addr     = bus.addr[int'(t_id) * AW +: AW];
            t_wdata    = bus.wdata[int'(t_id) * DW +: DW];
            t_ack      = cyc + 2 + (t_we ? 0 : WC);
            last_gnt   = int'(t_id);
            txn_active = 1;
        end
    endtask

    task automatic step();
        commit();
        tick();
    endtask

    task automatic set_cmd(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.we[i]              = w;
        bus.addr[i*AW +: AW]   = a;
        bus.wdata[i*DW +: DW]  = d;
    endtask

    task automatic wait_idle();
        bus.req = 3'b000;
        for (int n = 0; n < 40 && txn_active; n++) step();
        step();
    endtask

    // One isolated transaction; reports observed latencies relative to the request cycle.
    task automatic txn(input int id, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int cs_lat, output int ack_lat, output logic [AW-1:0] a_seen,
                       output logic [DW-1:0] d_seen, output logic we_seen,
                       output logic [2:0] ack_seen, output logic [DW-1:0] r_seen,
                       output logic [DW-1:0] r_exp);
        int t0;
        wait_idle();
        bus.req = 3'b001 << id;
        set_cmd(id, w, a, d);
        t0 = cyc;
        cs_lat = -1; ack_lat = -1;
        a_seen = '0; d_seen = '0; we_seen = 1'b0; ack_seen = '0; r_seen = '0; r_exp = '0;
        for (int n = 0; n < 40 && ack_lat < 0; n++) begin
            step();
            if (bus.mem_cs && cs_lat < 0) begin
                cs_lat  = cyc - t0;
                a_seen  = bus.mem_addr;
                d_seen  = bus.mem_wdata;
                we_seen = bus.mem_we;
            end
            if (|bus.ack) begin
                ack_lat  = cyc - t0;
                ack_seen = bus.ack;
                r_seen   = bus.rdata;
                r_exp    = hist[(t0 + 1 + WC) % 64];
                bus.req  = 3'b000;
            end
        end
    endtask

    initial begin
        int            order [3];
        int            exp_order [3];
        int            got_n, cs_lat, ack_lat, t0, n_cs, n_ack;
        int            ack_c [3];
        logic [AW-1:0] a_seen;
        logic [DW-1:0] d_seen, r_seen, r_exp, rdata_before;
        logic          we_seen;
        logic [2:0]    ack_seen;
        bit            hold_off [3];
        bit            got;

        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.mem_rdata = '0;
        reset = 1'b1;
        txn_active = 0;
        e_addr = '0; e_wdata = '0; e_rdata = '0; e_gnt = '0;
        last_gnt = 2;
        repeat (2) @(posedge clk);
        tick();
        step();
        step();
        reset = 1'b0;

        // simultaneous requests, each drops after its own ack
        for (int i = 0; i < 3; i++) begin
            order[i] = 3;
            set_cmd(i, 1'b0, AW'($urandom), DW'($urandom));
        end
        bus.req = 3'b111;
        got_n = 0;
        for (int n = 0; n < 60 && got_n < 3; n++) begin
            step();
            for (int i = 0; i < 3; i++)
                if (bus.ack[i] && got_n < 3) begin
                    order[got_n] = i;
                    got_n++;
                    bus.req[i] = 1'b0;
                end
        end
`ifdef MC8051_ARB_RR_EN
        exp_order = '{0, 1, 2};
`else
        exp_order = '{2, 1, 0};
`endif
        check("order0", order[0], exp_order[0]);
        check("order1", order[1], exp_order[1]);
        check("order2", order[2], exp_order[2]);

        // IF read of 0x1234
        txn(0, 1'b0, 16'h1234, 8'h00, cs_lat, ack_lat, a_seen, d_seen, we_seen, ack_seen, r_seen, r_exp);
        check("rd_cs_lat",  cs_lat,  1);
        check("rd_ack_lat", ack_lat, 2 + WC);
        check("rd_addr",    a_seen,  16'h1234);
        check("rd_we",      we_seen, 1'b0);
        check("rd_ack",     ack_seen, 3'b001);
        check("rd_data",    r_seen,  r_exp);

        // DX write 0x8000 / 0x5A, rdata must hold
        rdata_before = e_rdata;
        txn(1, 1'b1, 16'h8000, 8'h5A, cs_lat, ack_lat, a_seen, d_seen, we_seen, ack_seen, r_seen, r_exp);
        check("wr_cs_lat",  cs_lat,  1);
        check("wr_ack_lat", ack_lat, 2);
        check("wr_addr",    a_seen,  16'h8000);
        check("wr_wdata",   d_seen,  8'h5A);
        check("wr_we",      we_seen, 1'b1);
        check("wr_ack",     ack_seen, 3'b010);
        check("wr_rdata",   r_seen,  rdata_before);

        // DBG read
        txn(2, 1'b0, 16'hBEEF, 8'h00, cs_lat, ack_lat, a_seen, d_seen, we_seen, ack_seen, r_seen, r_exp);
        check("dbg_cs_lat",  cs_lat,  1);
        check("dbg_ack_lat", ack_lat, 2 + WC);
        check("dbg_ack",     ack_seen, 3'b100);
        check("dbg_data",    r_seen,  r_exp);

        // reset during the second WAIT cycle of an IF read
        wait_idle();
        bus.req = 3'b001;
        set_cmd(0, 1'b0, 16'h0042, 8'h00);
        t0 = cyc;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_busy",   bus.busy,   1'b0);
        check("rst_mem_cs", bus.mem_cs, 1'b0);
        check("rst_ack",    bus.ack,    3'b000);
        got = 0;
        ack_lat = -1;
        for (int n = 0; n < 30 && !got; n++) begin
            step();
            if (bus.ack[0]) begin
                got = 1;
                ack_lat = cyc - (t0 + 4);
                bus.req = 3'b000;
            end
        end
        check("rst_regrant",     got, 1'b1);
        check("rst_regrant_lat", ack_lat, 2 + WC);

        // IF holds req for three back-to-back reads
        wait_idle();
        bus.req = 3'b001;
        set_cmd(0, 1'b0, AW'($urandom), 8'h00);
        n_ack = 0; n_cs = 0;
        ack_c = '{0, 0, 0};
        for (int n = 0; n < 60 && n_ack < 3; n++) begin
            step();
            if (bus.mem_cs) n_cs++;
            if (bus.ack[0]) begin
                ack_c[n_ack] = cyc;
                n_ack++;
                if (n_ack < 3) set_cmd(0, 1'b0, AW'($urandom), 8'h00);
                else bus.req = 3'b000;
            end
        end
        check("b2b_acks",    n_ack, 3);
        check("b2b_period1", ack_c[1] - ack_c[0], WC + 3);
        check("b2b_period2", ack_c[2] - ack_c[1], WC + 3);
        check("b2b_cs",      n_cs, 3);

        // random traffic: held/back-to-back requests, mid-transaction drops, stray resets
        wait_idle();
        hold_off = '{0, 0, 0};
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (bus.ack[i]) begin
                    hold_off[i] = 0;
                    if (bus.req[i] && $urandom_range(0, 1) == 1)
                        set_cmd(i, 1'($urandom), AW'($urandom), DW'($urandom));
                    else
                        bus.req[i] = 1'b0;
                end else if (!bus.req[i] && !hold_off[i] && $urandom_range(0, 3) == 0) begin
                    bus.req[i] = 1'b1;
                    set_cmd(i, 1'($urandom), AW'($urandom), DW'($urandom));
                end else if (bus.req[i] && txn_active && int'(t_id) == i && cyc > t_start &&
                             $urandom_range(0, 15) == 0) begin
                    bus.req[i]  = 1'b0;
                    hold_off[i] = 1;
                end
            end
            reset = ($urandom_range(0, 299) == 0);
            if (reset) hold_off = '{0, 0, 0};
            step();
        end
        reset = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
